// File: rtl/capture_buffer.sv
// Circular sample capture memory that freezes one trigger-aligned frame for the display reader.
// Optional post-read re-arm holdoff is built in when CAPTURE_HOLDOFF_EN is defined.
module capture_buffer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int PRE_DEPTH = 64,
    parameter int HOLDOFF   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic              trigger,
    input  logic              run,
    input  logic              single,
    output logic              rst_trig,
    output logic              frame_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_done,
    output logic [2:0]        state
);

    localparam int DEPTH      = 1 << ADDR_W;
    localparam int POST_DEPTH = DEPTH - PRE_DEPTH;
    localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'(POST_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_OFFSET = ADDR_W'(PRE_DEPTH);
    localparam bit PARAMS_OK = (PRE_DEPTH >= 1) && (PRE_DEPTH < DEPTH) && (HOLDOFF >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("capture_buffer: PRE_DEPTH must be 1..DEPTH-1 and HOLDOFF >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_HOLD    = 3'd4,
        S_HOLDOFF = 3'd5
    } state_t;

    state_t state_q;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] rd_index;
    logic              single_q;
    logic              wr_en;
    logic              holdoff_done;

`ifdef CAPTURE_HOLDOFF_EN
    localparam int HO_W = $clog2(HOLDOFF + 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF - 1);
    logic [HO_W-1:0] holdoff_cnt;

    always_ff @(posedge clk) begin
        if (rst || state_q != S_HOLDOFF) begin
            holdoff_cnt <= '0;
        end else if (sample_valid) begin
            holdoff_cnt <= holdoff_cnt + 1'b1;
        end
    end

    assign holdoff_done = sample_valid && (holdoff_cnt == HO_LAST);
`else
    assign holdoff_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Trigger wins over an abort in ARMED; POST always runs the frame to completion.
    always_comb begin
        state_next = state_q;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_next = S_FILL;
            end
            S_FILL: begin
                wr_en = sample_valid;
                if (!run) begin
                    state_next = S_IDLE;
                end else if (sample_valid && pre_cnt == PRE_LAST) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                wr_en = sample_valid;
                if (trigger) begin
                    state_next = (sample_valid && POST_DEPTH == 1) ? S_HOLD : S_POST;
                end else if (!run) begin
                    state_next = S_IDLE;
                end
            end
            S_POST: begin
                wr_en = sample_valid;
                if (sample_valid && post_cnt == POST_LAST) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (rd_done) begin
                    if (single_q || !run) begin
                        state_next = S_IDLE;
                    end else begin
`ifdef CAPTURE_HOLDOFF_EN
                        state_next = S_HOLDOFF;
`else
                        state_next = S_FILL;
`endif
                    end
                end
            end
`ifdef CAPTURE_HOLDOFF_EN
            S_HOLDOFF: begin
                if (!run) begin
                    state_next = S_IDLE;
                end else if (holdoff_done) begin
                    state_next = S_FILL;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // The trigger sample sits at start_ptr + PRE_DEPTH, so only the frame start is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            start_ptr   <= '0;
            single_q    <= 1'b0;
            rst_trig    <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            rst_trig    <= (state_next == S_FILL) && (state_q != S_FILL);
            frame_ready <= (state_next == S_HOLD);
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (state_q == S_IDLE && state_next == S_FILL) single_q <= single;

            if (state_q != S_FILL) begin
                pre_cnt <= '0;
            end else if (sample_valid) begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            case (state_q)
                S_ARMED: post_cnt <= {{(ADDR_W-1){1'b0}}, sample_valid};
                S_POST:  if (sample_valid) post_cnt <= post_cnt + 1'b1;
                default: post_cnt <= '0;
            endcase

            if (state_q == S_ARMED && trigger) start_ptr <= wr_ptr - PRE_OFFSET;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr] <= sample;
    end

    assign rd_index = start_ptr + rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_index];
        end
    end

    assign state = state_q;

endmodule
